// File: rtl/adder_bist.sv
// adder_bist: exhaustive self-checking BIST engine for a W-bit adder.
// Walks every {b,a} operand pair in stride-STEP order and drives it onto the DUT.
// Compares the DUT sum against a+b, delayed through a LAT-deep line.
// Reports pass/fail, the first failing vector and the count of checked vectors.
module adder_bist #(
    parameter int W    = 4,
    parameter int LAT  = 0,
    parameter int STEP = 1
) (
    input  logic           ck_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [W:0]     s_i,
    output logic [W-1:0]   a_o,
    output logic [W-1:0]   b_o,
    output logic           busy_o,
    output logic           done_o,
    output logic           pass_o,
    output logic [W-1:0]   fail_a_o,
    output logic [W-1:0]   fail_b_o,
    output logic [W:0]     fail_s_o,
    output logic [2*W:0]   vec_cnt_o
);

    // N = 2**(2W) vectors; the index stride wraps modulo N.
    localparam logic [2*W:0]   N_V    = {1'b1, {(2*W){1'b0}}};
    localparam logic [2*W:0]   LAST_V = {1'b0, {(2*W){1'b1}}};
    localparam logic [2*W-1:0] STEP_V = (2*W)'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Reference sum: zero-extended operands, carry kept.
    function automatic logic [W:0] exp_sum(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_sum = {1'b0, x} + {1'b0, y};
    endfunction

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic             v0_q, v0_d;
    logic [2*W-1:0]   nxt_q, nxt_d;
    logic [2*W:0]     iss_q, iss_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [W-1:0]     fail_a_q, fail_a_d, fail_b_q, fail_b_d;
    logic [W:0]       fail_s_q, fail_s_d;
    logic [2*W:0]     vec_cnt_q, vec_cnt_d;

    logic             busy_s;
    logic             start_ok_s;
    logic             chk_v_s;
    logic [W-1:0]     chk_a_s, chk_b_s;
    logic [W:0]       chk_e_s;
    logic             chk_en_s, mism_s, last_chk_s;

    assign busy_s     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign start_ok_s = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // The vector on a,b is checked LAT cycles later; the line carries a, b, expected sum and valid.
    if (LAT == 0) begin : g_nolat
        assign chk_v_s = v0_q;
        assign chk_a_s = a_q;
        assign chk_b_s = b_q;
        assign chk_e_s = exp_sum(a_q, b_q);
    end else begin : g_lat
        logic [LAT-1:0] dv_q;
        logic [W-1:0]   da_q [LAT];
        logic [W-1:0]   db_q [LAT];
        logic [W:0]     de_q [LAT];

        // Delay line shift; valid bits are flushed whenever no run is in progress.
        always_ff @(posedge ck_i) begin
            if (rst_i) begin
                dv_q <= '0;
                for (int i = 0; i < LAT; i++) begin
                    da_q[i] <= '0;
                    db_q[i] <= '0;
                    de_q[i] <= '0;
                end
            end else begin
                dv_q[0] <= v0_q && busy_s;
                da_q[0] <= a_q;
                db_q[0] <= b_q;
                de_q[0] <= exp_sum(a_q, b_q);
                for (int i = 1; i < LAT; i++) begin
                    dv_q[i] <= dv_q[i-1] && busy_s;
                    da_q[i] <= da_q[i-1];
                    db_q[i] <= db_q[i-1];
                    de_q[i] <= de_q[i-1];
                end
            end
        end

        assign chk_v_s = dv_q[LAT-1];
        assign chk_a_s = da_q[LAT-1];
        assign chk_b_s = db_q[LAT-1];
        assign chk_e_s = de_q[LAT-1];
    end

    assign chk_en_s   = chk_v_s && busy_s;
    assign mism_s     = chk_en_s && (s_i != chk_e_s);
    assign last_chk_s = chk_en_s && !mism_s && (vec_cnt_q == LAST_V);

    // State register.
    always_ff @(posedge ck_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a mismatch aborts straight to DONE from RUN or DRAIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_RUN;
                else         state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (mism_s || last_chk_s)  state_d = ST_DONE;
                else if (iss_q == LAST_V)  state_d = ST_DRAIN;
                else                       state_d = ST_RUN;
            end
            ST_DRAIN: begin
                if (mism_s || last_chk_s) state_d = ST_DONE;
                else                      state_d = ST_DRAIN;
            end
            ST_DONE: begin
                if (start_i) state_d = ST_RUN;
                else         state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values: vector issue, result capture and counters.
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        v0_d      = 1'b0;
        nxt_d     = nxt_q;
        iss_d     = iss_q;
        pass_d    = pass_q;
        fail_a_d  = fail_a_q;
        fail_b_d  = fail_b_q;
        fail_s_d  = fail_s_q;
        vec_cnt_d = vec_cnt_q;

        if (start_ok_s) begin
            // Vector 0 is {b,a} = 0; the restart clears all results.
            a_d       = '0;
            b_d       = '0;
            v0_d      = 1'b1;
            nxt_d     = STEP_V;
            iss_d     = {{(2*W){1'b0}}, 1'b1};
            pass_d    = 1'b0;
            fail_a_d  = '0;
            fail_b_d  = '0;
            fail_s_d  = '0;
            vec_cnt_d = '0;
        end else if ((state_q == ST_RUN) && !mism_s) begin
            {b_d, a_d} = nxt_q;
            v0_d       = 1'b1;
            nxt_d      = nxt_q + STEP_V;
            iss_d      = iss_q + {{(2*W){1'b0}}, 1'b1};
        end else begin
            v0_d = 1'b0;
        end

        if (chk_en_s) begin
            vec_cnt_d = vec_cnt_q + {{(2*W){1'b0}}, 1'b1};
        end else begin
            vec_cnt_d = vec_cnt_d;
        end

        if (mism_s) begin
            pass_d   = 1'b0;
            fail_a_d = chk_a_s;
            fail_b_d = chk_b_s;
            fail_s_d = s_i;
        end else if (last_chk_s) begin
            pass_d = 1'b1;
        end else begin
            pass_d = pass_d;
        end

        if ((state_d == ST_IDLE) || (state_d == ST_DONE)) begin
            a_d = '0;
            b_d = '0;
        end else begin
            a_d = a_d;
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // Datapath and status registers.
    always_ff @(posedge ck_i) begin
        if (rst_i) begin
            a_q       <= '0;
            b_q       <= '0;
            v0_q      <= 1'b0;
            nxt_q     <= '0;
            iss_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_a_q  <= '0;
            fail_b_q  <= '0;
            fail_s_q  <= '0;
            vec_cnt_q <= '0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            v0_q      <= v0_d;
            nxt_q     <= nxt_d;
            iss_q     <= iss_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_a_q  <= fail_a_d;
            fail_b_q  <= fail_b_d;
            fail_s_q  <= fail_s_d;
            vec_cnt_q <= vec_cnt_d;
        end
    end

    assign a_o       = a_q;
    assign b_o       = b_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign pass_o    = pass_q;
    assign fail_a_o  = fail_a_q;
    assign fail_b_o  = fail_b_q;
    assign fail_s_o  = fail_s_q;
    assign vec_cnt_o = vec_cnt_q;

endmodule

// File: tb/tb_adder_bist.sv
// tb_adder_bist: three BIST engines (W4/LAT0, W4/LAT2, W2/STEP3) each with a bench adder model.
module tb_adder_bist;

    logic       ck;
    logic       rst;
    logic [2:0] start_v;
    logic       stuck;

    // Instance 0: W=4, LAT=0, STEP=1, optional s[0] stuck-at-0.
    logic [4:0] s0;
    logic [3:0] a0, b0, fa0, fb0;
    logic [4:0] fs0;
    logic [8:0] cnt0;
    logic       busy0, done0, pass0;

    // Instance 1: W=4, LAT=2, STEP=1, two-stage pipelined adder.
    logic [4:0] s1, p1_q, p2_q;
    logic [3:0] a1, b1, fa1, fb1;
    logic [4:0] fs1;
    logic [8:0] cnt1;
    logic       busy1, done1, pass1;

    // Instance 2: W=2, LAT=0, STEP=3.
    logic [2:0] s2;
    logic [1:0] a2, b2, fa2, fb2;
    logic [2:0] fs2;
    logic [4:0] cnt2;
    logic       busy2, done2, pass2;

    int sel;
    int mon_a, mon_b, mon_busy, mon_done, mon_pass, mon_fa, mon_fb, mon_fs, mon_cnt;
    int total;
    int passed;

    typedef struct {
        int sel;
        bit stuck;
        int lat;
        int pass;
        int cnt;
        int fa;
        int fb;
        int fs;
    } rec_t;

    rec_t tbl [5];
    int   seen [16];

    adder_bist #(.W(4), .LAT(0), .STEP(1)) u0 (
        .ck_i(ck), .rst_i(rst), .start_i(start_v[0]), .s_i(s0),
        .a_o(a0), .b_o(b0), .busy_o(busy0), .done_o(done0), .pass_o(pass0),
        .fail_a_o(fa0), .fail_b_o(fb0), .fail_s_o(fs0), .vec_cnt_o(cnt0)
    );

    adder_bist #(.W(4), .LAT(2), .STEP(1)) u1 (
        .ck_i(ck), .rst_i(rst), .start_i(start_v[1]), .s_i(s1),
        .a_o(a1), .b_o(b1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
        .fail_a_o(fa1), .fail_b_o(fb1), .fail_s_o(fs1), .vec_cnt_o(cnt1)
    );

    adder_bist #(.W(2), .LAT(0), .STEP(3)) u2 (
        .ck_i(ck), .rst_i(rst), .start_i(start_v[2]), .s_i(s2),
        .a_o(a2), .b_o(b2), .busy_o(busy2), .done_o(done2), .pass_o(pass2),
        .fail_a_o(fa2), .fail_b_o(fb2), .fail_s_o(fs2), .vec_cnt_o(cnt2)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Adder models feeding the engines.
    assign s0 = ({1'b0, a0} + {1'b0, b0}) & ~{4'b0000, stuck};
    assign s2 = {1'b0, a2} + {1'b0, b2};
    assign s1 = p2_q;

    // Two-stage pipelined adder for the LAT=2 engine.
    always_ff @(posedge ck) begin
        p1_q <= {1'b0, a1} + {1'b0, b1};
        p2_q <= p1_q;
    end

    // Select the outputs of the engine under test.
    always_comb begin
        mon_a = 0; mon_b = 0; mon_busy = 0; mon_done = 0; mon_pass = 0;
        mon_fa = 0; mon_fb = 0; mon_fs = 0; mon_cnt = 0;
        case (sel)
            0: begin
                mon_a = int'(a0); mon_b = int'(b0); mon_busy = int'(busy0);
                mon_done = int'(done0); mon_pass = int'(pass0); mon_fa = int'(fa0);
                mon_fb = int'(fb0); mon_fs = int'(fs0); mon_cnt = int'(cnt0);
            end
            1: begin
                mon_a = int'(a1); mon_b = int'(b1); mon_busy = int'(busy1);
                mon_done = int'(done1); mon_pass = int'(pass1); mon_fa = int'(fa1);
                mon_fb = int'(fb1); mon_fs = int'(fs1); mon_cnt = int'(cnt1);
            end
            default: begin
                mon_a = int'(a2); mon_b = int'(b2); mon_busy = int'(busy2);
                mon_done = int'(done2); mon_pass = int'(pass2); mon_fa = int'(fa2);
                mon_fb = int'(fb2); mon_fs = int'(fs2); mon_cnt = int'(cnt2);
            end
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Wait (bounded) for done; n = edges after the start edge.
    task automatic wait_done(output int n);
        n = 0;
        while (n < 1000 && mon_done != 1) begin
            @(posedge ck);
            #1;
            n++;
        end
    endtask

    // Pulse start for one edge on the selected engine, then wait for done.
    task automatic do_run(output int n);
        @(negedge ck);
        start_v[sel] = 1'b1;
        @(posedge ck);
        #1;
        start_v[sel] = 1'b0;
        wait_done(n);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a"}, mon_a, 0);
        check({tag, "_b"}, mon_b, 0);
        check({tag, "_busy"}, mon_busy, 0);
        check({tag, "_done"}, mon_done, 0);
        check({tag, "_pass"}, mon_pass, 0);
        check({tag, "_cnt"}, mon_cnt, 0);
        check({tag, "_fa"}, mon_fa, 0);
        check({tag, "_fb"}, mon_fb, 0);
        check({tag, "_fs"}, mon_fs, 0);
    endtask

    initial begin
        int n;
        int uniq;
        total   = 0;
        passed  = 0;
        sel     = 0;
        stuck   = 1'b0;
        start_v = 3'b000;
        rst     = 1'b1;

        //          sel stuck lat  pass cnt  fa fb fs
        tbl[0] = '{0, 1'b0, 256, 1, 256, 0, 0, 0};
        tbl[1] = '{0, 1'b1, 2,   0, 2,   1, 0, 0};
        tbl[2] = '{0, 1'b0, 256, 1, 256, 0, 0, 0};
        tbl[3] = '{1, 1'b0, 258, 1, 256, 0, 0, 0};
        tbl[4] = '{2, 1'b0, 16,  1, 16,  0, 0, 0};

        repeat (3) @(posedge ck);
        #1;
        check_zero("reset");
        @(negedge ck);
        rst = 1'b0;
        repeat (2) @(posedge ck);

        // Table-driven runs.
        for (int i = 0; i < 5; i++) begin
            sel = tbl[i].sel;
            @(negedge ck);
            stuck = tbl[i].stuck;
            do_run(n);
            check($sformatf("r%0d_latency", i), n, tbl[i].lat);
            check($sformatf("r%0d_done", i), mon_done, 1);
            check($sformatf("r%0d_busy", i), mon_busy, 0);
            check($sformatf("r%0d_pass", i), mon_pass, tbl[i].pass);
            check($sformatf("r%0d_vec_cnt", i), mon_cnt, tbl[i].cnt);
            check($sformatf("r%0d_fail_a", i), mon_fa, tbl[i].fa);
            check($sformatf("r%0d_fail_b", i), mon_fb, tbl[i].fb);
            check($sformatf("r%0d_fail_s", i), mon_fs, tbl[i].fs);
            check($sformatf("r%0d_a_idle", i), mon_a, 0);
            check($sformatf("r%0d_b_idle", i), mon_b, 0);
            repeat (3) @(posedge ck);
            #1;
            check($sformatf("r%0d_done_hold", i), mon_done, 1);
        end
        @(negedge ck);
        stuck = 1'b0;

        // W=2, STEP=3: every {b,a} pair appears exactly once during RUN.
        sel = 2;
        for (int k = 0; k < 16; k++) seen[k] = 0;
        @(negedge ck);
        start_v[2] = 1'b1;
        @(posedge ck);
        #1;
        start_v[2] = 1'b0;
        for (int k = 0; k < 16; k++) begin
            seen[{b2, a2}] = seen[{b2, a2}] + 1;
            @(posedge ck);
            #1;
        end
        uniq = 0;
        for (int k = 0; k < 16; k++) begin
            if (seen[k] == 1) uniq++;
        end
        check("cover_pairs_once", uniq, 16);
        check("cover_done", mon_done, 1);
        check("cover_pass", mon_pass, 1);
        check("cover_cnt", mon_cnt, 16);

        // Reset in the middle of a run, then a full clean run.
        sel = 0;
        @(negedge ck);
        start_v[0] = 1'b1;
        @(posedge ck);
        #1;
        start_v[0] = 1'b0;
        repeat (100) @(posedge ck);
        #1;
        check("mid_a_vec100", mon_a, 4);
        check("mid_b_vec100", mon_b, 6);
        check("mid_busy", mon_busy, 1);
        @(negedge ck);
        rst = 1'b1;
        @(posedge ck);
        #1;
        check_zero("midrst");
        @(negedge ck);
        rst = 1'b0;
        do_run(n);
        check("after_rst_latency", n, 256);
        check("after_rst_pass", mon_pass, 1);
        check("after_rst_cnt", mon_cnt, 256);

        // Start held high through RUN must not restart the run.
        @(negedge ck);
        start_v[0] = 1'b1;
        @(posedge ck);
        #1;
        n = 0;
        while (n < 1000 && mon_done != 1) begin
            if (n == 100) start_v[0] = 1'b0;
            @(posedge ck);
            #1;
            n++;
        end
        check("held_latency", n, 256);
        check("held_cnt", mon_cnt, 256);
        check("held_pass", mon_pass, 1);

        // Restart from DONE: fields cleared at the start edge, second run passes.
        @(negedge ck);
        start_v[0] = 1'b1;
        @(posedge ck);
        #1;
        start_v[0] = 1'b0;
        check("restart_pass_clr", mon_pass, 0);
        check("restart_cnt_clr", mon_cnt, 0);
        check("restart_done_clr", mon_done, 0);
        check("restart_busy", mon_busy, 1);
        check("restart_a0", mon_a, 0);
        wait_done(n);
        check("restart_latency", n, 256);
        check("restart_pass", mon_pass, 1);
        check("restart_cnt", mon_cnt, 256);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
